// File: rtl/pieo_enq_fifo_tracker_pkg.sv
// Shared definitions for the PIEO enqueue-side FIFO tracker: per-FIFO state
// encoding, default sizing and a sizing consistency check.
package pieo_enq_fifo_tracker_pkg;

  localparam int unsigned NUM_FIFO_DEF = 3;
  localparam int unsigned ID_LOG_DEF   = 2;
  localparam int unsigned CNT_LOG_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_PIEO = 2'd1,
    ST_SENDING = 2'd2
  } fifo_state_e;

  // Ids must cover every FIFO; the counter must hold NUM_FIFO without wrapping.
  function automatic bit cfg_ok(input int unsigned num_fifo, input int unsigned id_log,
                                input int unsigned cnt_log);
    return (num_fifo > 0) && ((1 << id_log) >= num_fifo) && ((1 << cnt_log) > num_fifo);
  endfunction

endpackage

// File: rtl/pieo_enq_fifo_tracker_rr.sv
// Combinational round-robin first-set finder: first set bit of mask at or
// after ptr, wrapping at N.
module rr_arbiter_ptr #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic         found_c,
  output logic [W-1:0] idx_c
);

  int          pos;
  logic [W-1:0] cand;

  // Scan from the far end so the candidate nearest ptr wins last.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    pos     = 0;
    cand    = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= int'(N)) pos = pos - int'(N);
      cand = W'(pos);
      if (mask[cand]) begin
        found_c = 1'b1;
        idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/pieo_enq_fifo_tracker.sv
// Tracks per-FIFO PIEO occupancy (IDLE/IN_PIEO/SENDING) and round-robin offers
// one eligible FIFO at a time to the pre-enqueue shaper.
module pieo_enq_fifo_tracker
  import pieo_enq_fifo_tracker_pkg::*;
#(
  parameter int unsigned NUM_FIFO = NUM_FIFO_DEF,
  parameter int unsigned ID_LOG   = ID_LOG_DEF,
  parameter int unsigned CNT_LOG  = CNT_LOG_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_FIFO-1:0] fifo_not_empty,
  input  logic                pieo_ready,
  input  logic                pieo_deq_valid,
  input  logic [ID_LOG-1:0]   pieo_deq_fifo_id,
  input  logic [NUM_FIFO-1:0] pkt_done,
  output logic                fifos_not_enq_flag,
  output logic [ID_LOG-1:0]   fifo_id,
  output logic [CNT_LOG-1:0]  in_pieo_cnt,
  output logic                err
);

  if (!cfg_ok(NUM_FIFO, ID_LOG, CNT_LOG)) begin : g_cfg_err
    $error("pieo_enq_fifo_tracker: inconsistent NUM_FIFO/ID_LOG/CNT_LOG");
  end

  localparam logic [ID_LOG-1:0] LAST_ID = ID_LOG'(NUM_FIFO - 1);

  fifo_state_e         state_q [NUM_FIFO];
  fifo_state_e         state_d [NUM_FIFO];
  logic                flag_q, flag_d;
  logic [ID_LOG-1:0]   fifo_id_q, fifo_id_d;
  logic [ID_LOG-1:0]   ptr_q, ptr_d;
  logic [CNT_LOG-1:0]  cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                enq_c;
  logic                deq_in_range_c;
  logic                deq_ok_c;
  logic [ID_LOG-1:0]   scan_ptr_c;
  logic [NUM_FIFO-1:0] scan_mask_c;
  logic                found_c;
  logic [ID_LOG-1:0]   idx_c;

  assign enq_c          = pieo_ready & flag_q;
  assign deq_in_range_c = {1'b0, pieo_deq_fifo_id} < (ID_LOG + 1)'(NUM_FIFO);
  assign deq_ok_c       = pieo_deq_valid && deq_in_range_c &&
                          (state_q[pieo_deq_fifo_id] == ST_IN_PIEO);
  assign scan_ptr_c     = enq_c ? ((fifo_id_q == LAST_ID) ? '0 : fifo_id_q + ID_LOG'(1))
                                : ptr_q;

  // The FIFO being accepted this cycle is still IDLE but must not be reselected.
  always_comb begin
    scan_mask_c = '0;
    for (int i = 0; i < int'(NUM_FIFO); i++) begin
      scan_mask_c[i] = fifo_not_empty[i] && (state_q[i] == ST_IDLE) &&
                       !(enq_c && (fifo_id_q == ID_LOG'(i)));
    end
  end

  rr_arbiter_ptr #(
    .N (NUM_FIFO),
    .W (ID_LOG)
  ) u_rr (
    .mask    (scan_mask_c),
    .ptr     (scan_ptr_c),
    .found_c (found_c),
    .idx_c   (idx_c)
  );

  always_comb begin
    flag_d    = flag_q;
    fifo_id_d = fifo_id_q;
    ptr_d     = scan_ptr_c;
    cnt_d     = cnt_q;
    err_d     = err_q;
    for (int i = 0; i < int'(NUM_FIFO); i++) state_d[i] = state_q[i];

    if (!flag_q || enq_c) begin
      flag_d = found_c;
      if (found_c) fifo_id_d = idx_c;
    end

    if (enq_c) state_d[fifo_id_q] = ST_IN_PIEO;

    if (pieo_deq_valid) begin
      if (deq_ok_c) state_d[pieo_deq_fifo_id] = ST_SENDING;
      else          err_d = 1'b1;
    end

    for (int i = 0; i < int'(NUM_FIFO); i++) begin
      if (pkt_done[i]) begin
        if (state_q[i] == ST_SENDING) state_d[i] = ST_IDLE;
        else                          err_d = 1'b1;
      end
    end

    case ({enq_c, deq_ok_c})
      2'b10:   cnt_d = cnt_q + CNT_LOG'(1);
      2'b01:   cnt_d = cnt_q - CNT_LOG'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_FIFO); i++) state_q[i] <= ST_IDLE;
      flag_q    <= 1'b0;
      fifo_id_q <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_FIFO); i++) state_q[i] <= state_d[i];
      flag_q    <= flag_d;
      fifo_id_q <= fifo_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign fifos_not_enq_flag = flag_q;
  assign fifo_id            = fifo_id_q;
  assign in_pieo_cnt        = cnt_q;
  assign err                = err_q;

endmodule

// File: tb/tb_pieo_enq_fifo_tracker.sv
// Bench for pieo_enq_fifo_tracker: directed vector table, async reset check,
// then randomized traffic against a behavioural model.
module tb_pieo_enq_fifo_tracker;

  localparam int NF = 3;

  logic       clk;
  logic       rst;
  logic [2:0] fne;
  logic       rdy;
  logic       dv;
  logic [1:0] did;
  logic [2:0] done;
  logic       flag;
  logic [1:0] id;
  logic [1:0] cnt;
  logic       err;

  int n_vec;
  int n_bad;

  // Behavioural model: 0 idle, 1 queued in PIEO, 2 transmitting.
  int m_st [NF];
  int m_ptr;
  int m_flag;
  int m_id;
  int m_cnt;
  int m_err;

  typedef struct {
    int fne; int rdy; int dv; int did; int done; int reps;
    int eflag; int eid; int ecnt; int eerr;
  } vec_t;

  vec_t tbl[$];

  pieo_enq_fifo_tracker dut (
    .clk                (clk),
    .rst                (rst),
    .fifo_not_empty     (fne),
    .pieo_ready         (rdy),
    .pieo_deq_valid     (dv),
    .pieo_deq_fifo_id   (did),
    .pkt_done           (done),
    .fifos_not_enq_flag (flag),
    .fifo_id            (id),
    .in_pieo_cnt        (cnt),
    .err                (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) m_st[i] = 0;
    m_ptr = 0; m_flag = 0; m_id = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic model_step();
    int ns [NF];
    int enq, ncnt, nerr, nflag, nid, sp, j, d;
    for (int i = 0; i < NF; i++) ns[i] = m_st[i];
    enq  = (rdy && m_flag != 0) ? 1 : 0;
    ncnt = m_cnt;
    nerr = m_err;
    nflag = m_flag;
    nid  = m_id;
    if (enq != 0) begin
      ns[m_id] = 1;
      ncnt++;
    end
    if (dv) begin
      d = int'(did);
      if (d >= NF) nerr = 1;
      else if (m_st[d] == 1) begin
        ns[d] = 2;
        ncnt--;
      end else nerr = 1;
    end
    for (int i = 0; i < NF; i++) begin
      if (done[i]) begin
        if (m_st[i] == 2) ns[i] = 0;
        else nerr = 1;
      end
    end
    if (!(m_flag != 0 && enq == 0)) begin
      sp = (enq != 0) ? (m_id + 1) % NF : m_ptr;
      nflag = 0;
      for (int k = 0; k < NF; k++) begin
        j = (sp + k) % NF;
        if (nflag == 0 && fne[j] && m_st[j] == 0 && !(enq != 0 && j == m_id)) begin
          nflag = 1;
          nid = j;
        end
      end
    end
    if (enq != 0) m_ptr = (m_id + 1) % NF;
    for (int i = 0; i < NF; i++) m_st[i] = ns[i];
    m_cnt = ncnt; m_err = nerr; m_flag = nflag; m_id = nid;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input int f, input int r, input int v, input int d, input int p);
    fne = 3'(f); rdy = 1'(r); dv = 1'(v); did = 2'(d); done = 3'(p);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    model_reset();

    // fne rdy dv did done reps | flag id cnt err (id -1 = not checked)
    tbl.push_back('{5, 0, 0, 0, 0, 11, 1,  0, 0, 0});
    tbl.push_back('{5, 1, 0, 0, 0,  1, 1,  2, 1, 0});
    tbl.push_back('{5, 1, 0, 0, 0,  1, 0, -1, 2, 0});
    tbl.push_back('{5, 1, 1, 2, 0,  1, 0, -1, 1, 0});
    tbl.push_back('{5, 0, 0, 0, 4,  1, 0, -1, 1, 0});
    tbl.push_back('{5, 0, 0, 0, 0,  1, 1,  2, 1, 0});
    tbl.push_back('{5, 1, 0, 0, 0,  1, 0, -1, 2, 0});
    tbl.push_back('{7, 0, 0, 0, 0,  1, 1,  1, 2, 0});
    tbl.push_back('{7, 1, 1, 0, 0,  1, 0, -1, 2, 0});
    tbl.push_back('{7, 0, 1, 3, 2,  1, 0, -1, 2, 1});
    tbl.push_back('{7, 0, 0, 0, 0,  3, 0, -1, 2, 1});
    tbl.push_back('{7, 0, 1, 1, 0,  1, 0, -1, 1, 1});
    tbl.push_back('{7, 0, 0, 0, 3,  1, 0, -1, 1, 1});
    tbl.push_back('{7, 0, 0, 0, 0,  1, 1,  0, 1, 1});
    tbl.push_back('{7, 1, 0, 0, 0,  1, 1,  1, 2, 1});

    #12;
    chk("reset flag", int'(flag), 0);
    chk("reset fifo_id", int'(id), 0);
    chk("reset cnt", int'(cnt), 0);
    chk("reset err", int'(err), 0);
    rst = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        set_in(tbl[r].fne, tbl[r].rdy, tbl[r].dv, tbl[r].did, tbl[r].done);
        step();
        chk($sformatf("row%0d.%0d flag", r, k), int'(flag), tbl[r].eflag);
        if (tbl[r].eid >= 0) chk($sformatf("row%0d.%0d fifo_id", r, k), int'(id), tbl[r].eid);
        chk($sformatf("row%0d.%0d cnt", r, k), int'(cnt), tbl[r].ecnt);
        chk($sformatf("row%0d.%0d err", r, k), int'(err), tbl[r].eerr);
      end
    end

    // Two FIFOs queued and flag high: reset must clear outputs without an edge.
    set_in(0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async flag", int'(flag), 0);
    chk("async fifo_id", int'(id), 0);
    chk("async cnt", int'(cnt), 0);
    chk("async err", int'(err), 0);
    model_reset();
    #3;
    rst = 1'b0;

    for (int c = 0; c < 2000; c++) begin
      int i;
      int p;
      fne = 3'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 3) != 0);
      i   = int'($urandom_range(0, NF - 1));
      dv  = (m_st[i] == 1) && ($urandom_range(0, 2) == 0);
      did = 2'(i);
      p = 0;
      for (int q = 0; q < NF; q++)
        if (m_st[q] == 2 && $urandom_range(0, 3) == 0) p = p | (1 << q);
      if (c >= 1500 && $urandom_range(0, 49) == 0) begin
        dv  = 1'b1;
        did = 2'($urandom_range(0, 3));
        p   = p | (1 << $urandom_range(0, NF - 1));
      end
      done = 3'(p);
      step();
      chk("rand flag", int'(flag), m_flag);
      if (m_flag != 0) chk("rand fifo_id", int'(id), m_id);
      chk("rand cnt", int'(cnt), m_cnt);
      chk("rand err", int'(err), m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pieo_enq_fifo_tracker.md
Name: pieo_enq_fifo_tracker

Overview:
Upstream neighbour of the PIEO pre-enqueue shaper.
- Tracks, per FIFO, whether its head packet is eligible for PIEO, already enqueued in PIEO, or being transmitted.
- Round-robin selects one eligible FIFO and presents fifos_not_enq_flag/fifo_id to the shaper.
- Enforces at most one PIEO element per FIFO at any time.

Parameters:
- NUM_FIFO, 3, number of packet FIFOs tracked.
- ID_LOG, 2, width of a FIFO id; 2**ID_LOG >= NUM_FIFO.
- CNT_LOG, 2, width of the in-PIEO occupancy counter; 2**CNT_LOG > NUM_FIFO.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- fifo_not_empty  in  NUM_FIFO  bit i high when FIFO i holds at least one complete packet.
- pieo_ready  in  1  PIEO can accept an enqueue this cycle.
- pieo_deq_valid  in  1  PIEO dequeued an element this cycle.
- pieo_deq_fifo_id  in  ID_LOG  FIFO id of the dequeued element.
- pkt_done  in  NUM_FIFO  one-cycle pulse when FIFO i finishes transmitting its head packet.
- fifos_not_enq_flag  out  1  registered; a selected FIFO is offered to the shaper.
- fifo_id  out  ID_LOG  registered; selected FIFO id, valid when the flag is high.
- in_pieo_cnt  out  CNT_LOG  number of FIFOs in state IN_PIEO.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Per-FIFO state: IDLE, IN_PIEO, SENDING. Encoding is shared (see Decomposition).
- Reset (async, active-high): every FIFO goes to IDLE; fifos_not_enq_flag=0, fifo_id=0, in_pieo_cnt=0, err=0, round-robin pointer=0.
- eligible[i] = fifo_not_empty[i] and state[i]==IDLE. This is combinational.
- Enqueue event: pieo_ready and fifos_not_enq_flag in the same cycle. This matches the shaper's trigger condition.
- On an enqueue event, at the clock edge:
  - state[fifo_id] goes to IN_PIEO.
  - The pointer becomes fifo_id+1, wrapping at NUM_FIFO.
- Selection register:
  - If flag=1 and there is no enqueue event, hold fifo_id and flag unchanged. This keeps them stable for the shaper's combinational path.
  - Otherwise, load the first eligible FIFO scanning from the pointer with wrap-around. Eligibility is evaluated with the just-accepted FIFO excluded. Set flag=1 if one is found, else flag=0.
- Latency: a FIFO that becomes eligible at cycle t is offered at t+1 at the earliest.
- Back-to-back enqueues: one per cycle is possible when several FIFOs are eligible.
- Dequeue: pieo_deq_valid with state[pieo_deq_fifo_id]==IN_PIEO moves that FIFO to SENDING. If the FIFO is in any other state, the state is unchanged and err is set.
- pkt_done[i] with state[i]==SENDING moves FIFO i to IDLE. It becomes eligible again the next cycle if fifo_not_empty[i]. If FIFO i is not in SENDING, err is set.
- Simultaneous events on different FIFOs (enqueue, dequeue, pkt_done) all take effect in the same cycle.
- Dequeue of a FIFO in the same cycle as its own enqueue is impossible (it is not yet IN_PIEO) and is flagged as err.
- pieo_deq_fifo_id >= NUM_FIFO: ignored, err set.
- in_pieo_cnt:
  - +1 on an enqueue event.
  - -1 on a valid dequeue.
  - Unchanged when both happen in the same cycle.
  - Never wraps, since it is bounded by NUM_FIFO.
- fifo_not_empty dropping for a FIFO that is already selected: not permitted (nothing drains an un-enqueued FIFO). Selection holds regardless.

Decomposition:
- Shared package contains:
  - the per-FIFO state encoding (IDLE=0, IN_PIEO=1, SENDING=2);
  - the ID_LOG/NUM_FIFO consistency check.
- Natural sub-module: rr_arbiter_ptr. It is a combinational round-robin first-set finder taking (mask, pointer) and returning (found, index).

Test Plan:
- Reset, fifo_not_empty=3'b101, pieo_ready=0 -> flag=1, fifo_id=0 at cycle 1; both held for 10 cycles.
- From that state, pieo_ready=1 for 2 cycles -> FIFO 0 enqueued, then FIFO 2 offered and enqueued; flag=0 afterwards; in_pieo_cnt=2.
- Dequeue id 2, then pkt_done[2] pulse with fifo_not_empty[2]=1 -> FIFO 2 goes SENDING, then IDLE, then offered again one cycle after pkt_done; in_pieo_cnt goes 2->1->2 on re-enqueue.
- Same cycle: enqueue FIFO 1 and dequeue FIFO 0 -> in_pieo_cnt unchanged; FIFO 0=SENDING, FIFO 1=IN_PIEO.
- pkt_done[1] while FIFO 1 is IN_PIEO, and deq of id 3 -> err=1 and stays 1; states unchanged.
- Assert rst while 2 FIFOs are IN_PIEO and the flag is high -> all outputs 0 immediately (async), with no clock edge needed.
